// File: rtl/buffer_filas_circ.sv
// Circular row buffer: loads width_fil rows, then replays them oldest-first for N passes.
// Optional synchronous clear port enabled by defining BUFFER_FILAS_CLR_EN.
module buffer_filas_circ #(
    parameter int bit_depth = 8,
    parameter int width_fil = 16,
    parameter int width_col = 16
) (
    input  logic                           clk,
    input  logic                           rst,
`ifdef BUFFER_FILAS_CLR_EN
    input  logic                           clr,
`endif
    input  logic [bit_depth*width_col-1:0] fila_in,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           start,
    input  logic [3:0]                     passes,
    output logic [bit_depth*width_col-1:0] fila_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           full,
    output logic                           done
);
    localparam int DW = bit_depth * width_col;
    localparam int OW = $clog2(width_fil + 1);
    localparam int BW = $clog2(width_fil);

    typedef enum logic [1:0] {IDLE, LOAD, FULL, READ} state_t;

    state_t state, state_nxt;
    logic [width_fil-1:0][DW-1:0] rows, rows_nxt;
    logic [OW-1:0] occ;
    logic [BW-1:0] beat;
    logic [3:0]    pass_cnt, passes_lat;
    logic          clr_i, wr_en, rd_en, start_acc, beat_wrap, final_beat, load_done;

`ifdef BUFFER_FILAS_CLR_EN
    assign clr_i = clr;
`else
    assign clr_i = 1'b0;
`endif

    assign wr_en      = in_ready & in_valid;
    assign rd_en      = out_valid & out_ready;
    assign start_acc  = (state == FULL) & start;
    assign beat_wrap  = (beat == BW'(width_fil - 1));
    assign final_beat = rd_en & beat_wrap & (pass_cnt == passes_lat - 4'd1);
    assign load_done  = wr_en & (occ == OW'(width_fil - 1));
    assign fila_out   = rows[width_fil-1];

    // Write shifts a fresh row in at 0; a read beat recirculates the oldest row back to 0.
    always_comb begin
        rows_nxt = rows;
        if (wr_en) begin
            rows_nxt[0] = fila_in;
            for (int i = 1; i < width_fil; i++) rows_nxt[i] = rows[i-1];
        end else if (rd_en) begin
            rows_nxt[0] = rows[width_fil-1];
            for (int i = 1; i < width_fil; i++) rows_nxt[i] = rows[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else if (clr_i) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wr_en) state_nxt = load_done ? FULL : LOAD;
            LOAD:    if (load_done) state_nxt = FULL;
            FULL:    if (start_acc) state_nxt = READ;
            READ:    if (final_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        full      = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            IDLE, LOAD: in_ready = 1'b1;
            FULL:       full = 1'b1;
            READ: begin
                full      = 1'b1;
                out_valid = 1'b1;
                out_last  = beat_wrap;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rows       <= '0;
            occ        <= '0;
            beat       <= '0;
            pass_cnt   <= '0;
            passes_lat <= '0;
            done       <= 1'b0;
        end else if (clr_i) begin
            rows       <= '0;
            occ        <= '0;
            beat       <= '0;
            pass_cnt   <= '0;
            passes_lat <= '0;
            done       <= 1'b0;
        end else begin
            rows <= rows_nxt;
            done <= final_beat;
            if (wr_en) occ <= occ + OW'(1);
            if (start_acc) begin
                passes_lat <= (passes == 4'd0) ? 4'd1 : passes;
                beat       <= '0;
                pass_cnt   <= '0;
            end else if (rd_en) begin
                if (beat_wrap) begin
                    beat     <= '0;
                    pass_cnt <= pass_cnt + 4'd1;
                end else begin
                    beat <= beat + BW'(1);
                end
            end
            if (final_beat) occ <= '0;
        end
    end

endmodule

// File: tb/tb_buffer_filas_circ.sv
// Bench for buffer_filas_circ: directed scenarios then random traffic, all checked
// every cycle against a queue-based model of the row buffer.
module tb_buffer_filas_circ;
    localparam int BD = 8, WF = 4, WC = 2, DW = BD * WC;

    logic          clk = 1'b0, rst = 1'b0;
    logic [DW-1:0] fila_in = '0;
    logic          in_valid = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic [3:0]    passes = '0;
    logic          in_ready, out_valid, out_last, full, done;
    logic [DW-1:0] fila_out;
`ifdef BUFFER_FILAS_CLR_EN
    logic          clr = 1'b0;
`endif

    buffer_filas_circ #(.bit_depth(BD), .width_fil(WF), .width_col(WC)) dut (
        .clk(clk), .rst(rst),
`ifdef BUFFER_FILAS_CLR_EN
        .clr(clr),
`endif
        .fila_in(fila_in), .in_valid(in_valid), .in_ready(in_ready),
        .start(start), .passes(passes), .fila_out(fila_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .full(full), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    // Model: q[0] newest row, q[WF-1] oldest; beats counted as a running total.
    logic [DW-1:0] q[$];
    int  occ_m, beat_m, total_m;
    bit  full_m, rd_m, done_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        q.delete();
        for (int i = 0; i < WF; i++) q.push_back('0);
        occ_m = 0; beat_m = 0; total_m = 0;
        full_m = 0; rd_m = 0; done_m = 0;
    endtask

    task automatic m_edge();
        logic [DW-1:0] x;
        done_m = 0;
`ifdef BUFFER_FILAS_CLR_EN
        if (clr) begin m_reset(); return; end
`endif
        if (rd_m) begin
            if (out_ready) begin
                x = q.pop_back();
                q.push_front(x);
                beat_m++;
                if (beat_m == total_m) begin
                    rd_m = 0; full_m = 0; occ_m = 0; done_m = 1;
                end
            end
        end else if (full_m) begin
            if (start) begin
                rd_m = 1; beat_m = 0;
                total_m = WF * ((passes == 4'd0) ? 1 : int'(passes));
            end
        end else if (in_valid) begin
            x = q.pop_back();
            q.push_front(fila_in);
            occ_m++;
            if (occ_m == WF) full_m = 1;
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".in_ready"},  in_ready,  !full_m);
        chk({ph, ".full"},      full,      full_m);
        chk({ph, ".out_valid"}, out_valid, rd_m);
        chk({ph, ".out_last"},  out_last,  rd_m && (beat_m % WF == WF - 1));
        chk({ph, ".done"},      done,      done_m);
        chk({ph, ".fila_out"},  fila_out,  q[WF-1]);
    endtask

    task automatic cyc(input string ph);
        @(posedge clk);
        m_edge();
        #1;
        check_all(ph);
    endtask

    task automatic load4(input string ph);
        in_valid = 1'b1;
        for (int k = 1; k <= WF; k++) begin
            fila_in = {2{8'(k)}};
            cyc(ph);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;
        cyc("post_reset");

        // Load four rows; oldest appears on fila_out once full.
        load4("load");
        chk("full_after_load", full, 1'b1);
        chk("in_ready_full", in_ready, 1'b0);
        chk("oldest_row", fila_out, 16'h0101);

        // Two passes, consumer always ready.
        passes = 4'd2; start = 1'b1; out_ready = 1'b1;
        cyc("start2");
        start = 1'b0;
        for (int b = 0; b < 2 * WF; b++) begin
            chk("seq2_row", fila_out, {2{8'(b % WF + 1)}});
            chk("seq2_last", out_last, (b % WF) == WF - 1);
            cyc("read2");
        end
        chk("done_pulse", done, 1'b1);
        cyc("after_done");
        chk("done_once", done, 1'b0);
        chk("idle_ready", in_ready, 1'b1);

        // Backpressure after the second beat holds row 0x0303.
        load4("reload");
        passes = 4'd1; start = 1'b1;
        cyc("start1");
        start = 1'b0;
        cyc("bp_beat1");
        cyc("bp_beat2");
        out_ready = 1'b0;
        repeat (3) begin
            cyc("bp_hold");
            chk("bp_row", fila_out, 16'h0303);
            chk("bp_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        cyc("bp_beat3");
        cyc("bp_beat4");
        chk("bp_done", done, 1'b1);

        // Start while loading is ignored; passes=0 gives one pass.
        in_valid = 1'b1; start = 1'b1;
        fila_in = 16'h0a0a; cyc("start_in_load");
        fila_in = 16'h0b0b; cyc("start_in_load");
        start = 1'b0;
        fila_in = 16'h0c0c; cyc("load_rest");
        fila_in = 16'h0d0d; cyc("load_rest");
        in_valid = 1'b0;
        chk("full_p0", full, 1'b1);
        passes = 4'd0; start = 1'b1;
        cyc("start0");
        start = 1'b0;
        repeat (WF) cyc("read0");
        chk("p0_done", done, 1'b1);
        cyc("p0_after");

        // Asynchronous reset in the middle of a read.
        load4("load_rst");
        passes = 4'd1; start = 1'b1;
        cyc("start_rst");
        start = 1'b0;
        cyc("rst_beat1");
        cyc("rst_beat2");
        #2;
        rst = 1'b0; out_ready = 1'b0;
        #1;
        m_reset();
        check_all("async_rst");
        chk("rst_fila_out", fila_out, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) cyc("rst_after");

`ifdef BUFFER_FILAS_CLR_EN
        // Synchronous clear wins over a simultaneous write.
        in_valid = 1'b1;
        fila_in = 16'h1111; cyc("clr_load");
        fila_in = 16'h2222; cyc("clr_load");
        fila_in = 16'h5555; clr = 1'b1;
        cyc("clr");
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_fila_out", fila_out, 16'h0000);
        chk("clr_ready", in_ready, 1'b1);
        load4("clr_reload");
        chk("clr_full", full, 1'b1);
`endif

        // Random traffic against the model.
        repeat (600) begin
            in_valid  = 1'($urandom_range(0, 1));
            fila_in   = DW'($urandom);
            start     = ($urandom_range(0, 3) == 0);
            passes    = 4'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            cyc("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
